// File: rtl/pix_bus_arbiter_pkg.sv
// Shared definitions for the two-port pixel write-path arbiter.
// State encoding, data width and port index constants.
package pix_bus_arbiter_pkg;

  localparam int DW = 17;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    REL  = 2'd2
  } state_e;

  localparam logic P0 = 1'b0;
  localparam logic P1 = 1'b1;

endpackage

// File: rtl/pix_bus_arbiter_mux.sv
// 17-bit 2:1 data mux selecting between the core store path and the
// sharpening engine in front of the output register.
module MUX17bit
  import pix_bus_arbiter_pkg::*;
(
  input  logic [DW-1:0] IN0,
  input  logic [DW-1:0] IN1,
  input  logic          sel,
  output logic [DW-1:0] OUT
);

  assign OUT = sel ? IN1 : IN0;

endmodule

// File: rtl/pix_bus_arbiter.sv
// Round-robin burst arbiter for the shared 17-bit pixel write path, with a
// single-entry registered valid/ready output stage toward the pixel buffer.
module pix_bus_arbiter #(
  parameter int DW    = 17,
  parameter int LEN_W = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             REQ0,
  input  logic [LEN_W-1:0] LEN0,
  input  logic             VALID0,
  input  logic [DW-1:0]    DATA0,
  output logic             READY0,
  output logic             GNT0,
  input  logic             REQ1,
  input  logic [LEN_W-1:0] LEN1,
  input  logic             VALID1,
  input  logic [DW-1:0]    DATA1,
  output logic             READY1,
  output logic             GNT1,
  output logic             SEL,
  output logic [DW-1:0]    O_DATA,
  output logic             O_VALID,
  input  logic             O_READY,
  output logic             BUSY
);

  import pix_bus_arbiter_pkg::*;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             sel_q, sel_d;
  logic             last_q, last_d;
  logic             ov_q, ov_d;
  logic [DW-1:0]    od_q, od_d;
  logic [DW-1:0]    mux_out;
  logic             can_load, own_valid, xfer_beat, win;

  MUX17bit u_mux (
    .IN0 (DATA0),
    .IN1 (DATA1),
    .sel (sel_q),
    .OUT (mux_out)
  );

  assign can_load  = !ov_q | O_READY;
  assign own_valid = sel_q ? VALID1 : VALID0;
  assign xfer_beat = (state_q == XFER) & own_valid & can_load;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    last_d  = last_q;
    win     = P0;
    if (REQ0 & REQ1) win = ~last_q;
    else if (REQ1)   win = P1;
    case (state_q)
      IDLE: begin
        // Hold off a port switch while the output still carries the other port's beat.
        if ((REQ0 | REQ1) && !(ov_q && (win != sel_q))) begin
          state_d = XFER;
          sel_d   = win;
          cnt_d   = win ? LEN1 : LEN0;
        end
      end
      XFER: begin
        if (xfer_beat) begin
          if (cnt_q == '0) begin
            state_d = REL;
            last_d  = sel_q;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      REL:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ov_d = ov_q;
    od_d = od_q;
    if (xfer_beat) begin
      ov_d = 1'b1;
      od_d = mux_out;
    end else if (O_READY) begin
      ov_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= P0;
      last_q  <= P1;
      ov_q    <= 1'b0;
      od_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
    end
  end

  assign GNT0    = (state_q == XFER) & (sel_q == P0);
  assign GNT1    = (state_q == XFER) & (sel_q == P1);
  assign READY0  = GNT0 & can_load;
  assign READY1  = GNT1 & can_load;
  assign SEL     = sel_q;
  assign O_DATA  = od_q;
  assign O_VALID = ov_q;
  assign BUSY    = (state_q != IDLE) | ov_q;

endmodule

// File: tb/tb_pix_bus_arbiter.sv
// Scoreboard bench for pix_bus_arbiter: accepted input beats are queued and
// matched against every word popped from the output stage.
module tb_pix_bus_arbiter;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [1:0]  req = '0;
  logic [1:0]  vld = '0;
  logic [3:0]  lens [2];
  logic [16:0] dat [2];
  logic        rdy0, rdy1, gnt0, gnt1;
  logic        SEL, O_VALID, BUSY;
  logic        O_READY = 1'b1;
  logic [16:0] O_DATA;
  wire  [1:0]  rdy = {rdy1, rdy0};
  wire  [1:0]  gnt = {gnt1, gnt0};

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [16:0] exp_q [$];
  int glog_p [$];
  int glog_c [$];

  pix_bus_arbiter dut (
    .CLK(CLK), .RESET(RESET),
    .REQ0(req[0]), .LEN0(lens[0]), .VALID0(vld[0]), .DATA0(dat[0]),
    .READY0(rdy0), .GNT0(gnt0),
    .REQ1(req[1]), .LEN1(lens[1]), .VALID1(vld[1]), .DATA1(dat[1]),
    .READY1(rdy1), .GNT1(gnt1),
    .SEL(SEL), .O_DATA(O_DATA), .O_VALID(O_VALID), .O_READY(O_READY),
    .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Output/scoreboard monitor, sampled on the falling edge.
  logic [1:0]  gnt_prev = '0;
  logic        sel_prev = 1'b0, rst_prev = 1'b1, ov_prev = 1'b0, ordy_prev = 1'b1;
  logic [16:0] od_prev = '0;
  always @(negedge CLK) begin
    if (!RESET) begin
      if (O_VALID && O_READY) begin
        if (exp_q.size() == 0) chk("sb_underflow", 32'(exp_q.size()), 1);
        else                   chk("sb_data", 32'(O_DATA), 32'(exp_q.pop_front()));
      end
      if (!rst_prev && ov_prev && !ordy_prev) begin
        chk("out_hold_valid", 32'(O_VALID), 1);
        chk("out_hold_data", 32'(O_DATA), 32'(od_prev));
      end
      for (int p = 0; p < 2; p++) begin
        if (vld[p] && rdy[p]) exp_q.push_back(dat[p]);
        if (rdy[p]) chk("ready_owner", 32'(gnt[p]), 1);
      end
      if (gnt == 2'b11) chk("gnt_excl", 32'(gnt), 0);
      if (gnt[0] && !gnt_prev[0]) begin
        glog_p.push_back(0); glog_c.push_back(cyc); chk("sel_at_gnt0", 32'(SEL), 0);
      end else if (gnt[1] && !gnt_prev[1]) begin
        glog_p.push_back(1); glog_c.push_back(cyc); chk("sel_at_gnt1", 32'(SEL), 1);
      end else if (!rst_prev) begin
        chk("sel_hold", 32'(SEL), 32'(sel_prev));
      end
    end
    gnt_prev  <= gnt;
    sel_prev  <= SEL;
    rst_prev  <= RESET;
    ov_prev   <= O_VALID;
    ordy_prev <= O_READY;
    od_prev   <= O_DATA;
  end

  // Drive one burst on port p; stall0 = cycles VALID stays low after grant.
  task automatic burst(input int p, input int len, input logic [16:0] d0, input int stall0);
    int n = 0;
    int g = 0;
    int st = stall0;
    bit acc;
    req[p] = 1'b1; lens[p] = 4'(len); dat[p] = d0; vld[p] = (stall0 == 0);
    while (n <= len && g < 400) begin
      @(negedge CLK); g++;
      acc = vld[p] && rdy[p];
      if (gnt[p] && st > 0) st--;
      @(posedge CLK); #1;
      if (acc) begin n++; dat[p] = d0 + 17'(n); end
      if (n > len) begin vld[p] = 1'b0; req[p] = 1'b0; end
      else vld[p] = (st == 0);
    end
    if (g >= 400) chk("burst_timeout", n, len + 1);
  endtask

  task automatic wait_gnt(input int p);
    int g = 0;
    while (!gnt[p] && g < 60) begin @(negedge CLK); g++; end
    if (!gnt[p]) chk("gnt_timeout", 32'(gnt[p]), 1);
  endtask

  initial begin
    lens[0] = '0; lens[1] = '0; dat[0] = '0; dat[1] = '0;
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int k, g;
    // Reset then single beat.
    repeat (2) @(posedge CLK); #1 RESET = 1'b0;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_ready", 32'(rdy), 0);
    chk("rst_sel", 32'(SEL), 0);
    chk("rst_ovalid", 32'(O_VALID), 0);
    chk("rst_odata", 32'(O_DATA), 0);
    chk("rst_busy", 32'(BUSY), 0);
    req[0] = 1'b1; lens[0] = 4'd0; vld[0] = 1'b1; dat[0] = 17'h1ABCD;
    @(negedge CLK); chk("gnt_lat_early", 32'(gnt0), 0);
    @(negedge CLK); chk("gnt_lat", 32'(gnt0), 1); chk("ready0_first", 32'(rdy0), 1);
    @(posedge CLK); #1 req[0] = 1'b0; vld[0] = 1'b0;
    @(negedge CLK);
    chk("single_ovalid", 32'(O_VALID), 1);
    chk("single_odata", 32'(O_DATA), 32'h1ABCD);
    chk("single_rel_gnt", 32'(gnt0), 0);
    chk("single_rel_busy", 32'(BUSY), 1);
    @(negedge CLK); chk("single_idle_busy", 32'(BUSY), 0);

    // Backpressure on port 1.
    fork
      burst(1, 3, 17'd1, 0);
      begin
        k = 0; g = 0;
        while (k < 2 && g < 60) begin @(negedge CLK); g++; if (vld[1] && rdy[1]) k++; end
        @(posedge CLK); #1 O_READY = 1'b0;
        repeat (3) begin
          @(negedge CLK);
          chk("bp_ready1", 32'(rdy1), 0);
          chk("bp_odata", 32'(O_DATA), 2);
        end
        @(posedge CLK); #1 O_READY = 1'b1;
      end
    join
    repeat (4) @(posedge CLK); #1;

    // Tie and round-robin.
    glog_p.delete(); glog_c.delete();
    fork
      begin burst(0, 1, 17'h10, 0); burst(0, 1, 17'h12, 0); end
      begin burst(1, 1, 17'h20, 0); burst(1, 1, 17'h22, 0); end
    join
    chk("rr_count", glog_p.size(), 4);
    for (int i = 0; i < glog_p.size() && i < 4; i++) chk("rr_order", glog_p[i], i % 2);
    for (int i = 1; i < glog_c.size() && i < 4; i++) chk("rr_gap", glog_c[i] - glog_c[i-1], 4);
    repeat (4) @(posedge CLK); #1;

    // Max burst with a mid-burst request from port 1.
    glog_p.delete(); glog_c.delete();
    fork
      begin
        burst(0, 15, 17'h100, 0);
        chk("max_gnt0_drop", 32'(gnt0), 0);
      end
      begin
        k = 0; g = 0;
        while (k < 5 && g < 60) begin @(negedge CLK); g++; if (vld[0] && rdy[0]) k++; end
        @(posedge CLK); #1;
        burst(1, 0, 17'h2A0, 0);
      end
    join
    chk("max_grants", glog_p.size(), 2);
    if (glog_c.size() >= 2) chk("max_gap", glog_c[1] - glog_c[0], 18);
    repeat (4) @(posedge CLK); #1;

    // Stalled owner.
    fork
      burst(0, 1, 17'h30, 10);
      begin repeat (2) @(posedge CLK); #1 burst(1, 0, 17'h40, 0); end
      begin
        wait_gnt(0);
        repeat (8) begin
          @(negedge CLK);
          chk("stall_gnt0", 32'(gnt0), 1);
          chk("stall_gnt1", 32'(gnt1), 0);
        end
      end
    join
    repeat (4) @(posedge CLK); #1;

    // Reset mid-burst on port 1, after port 0 became last owner.
    burst(0, 0, 17'h50, 0);
    repeat (3) @(posedge CLK); #1;
    req[1] = 1'b1; lens[1] = 4'd3; vld[1] = 1'b1; dat[1] = 17'h61;
    k = 0; g = 0;
    while (k < 1 && g < 60) begin @(negedge CLK); g++; if (vld[1] && rdy[1]) k++; end
    @(posedge CLK); #1 dat[1] = 17'h62; RESET = 1'b1;
    @(posedge CLK); #1 RESET = 1'b0; req[1] = 1'b0; vld[1] = 1'b0;
    chk("mid_rst_gnt", 32'(gnt), 0);
    chk("mid_rst_ovalid", 32'(O_VALID), 0);
    chk("mid_rst_sel", 32'(SEL), 0);
    chk("mid_rst_busy", 32'(BUSY), 0);
    exp_q.delete();
    glog_p.delete(); glog_c.delete();
    fork
      burst(0, 0, 17'h70, 0);
      burst(1, 0, 17'h80, 0);
    join
    chk("post_rst_grants", glog_p.size(), 2);
    if (glog_p.size() >= 2) begin
      chk("post_rst_tie_p0", glog_p[0], 0);
      chk("post_rst_then_p1", glog_p[1], 1);
    end

    repeat (6) @(posedge CLK); #1;
    chk("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pix_bus_arbiter.md
Name: pix_bus_arbiter

Overview:
Shares one 17-bit pixel write path between two requesters: port 0 is the DLX core store path and port 1 is the sharpening engine. Bursts are granted round-robin, and each grant is held for the requested burst length. The block drives the select of the downstream 17-bit 2:1 data mux and registers the selected word into a single-entry valid/ready output stage that feeds the pixel buffer.

Parameters:
DW, 17, data word width; fixed by the pixel datapath.
LEN_W, 4, burst length field width; LENx = beats-1, so bursts are 1..16 beats.

Ports:
CLK  in  1  system clock, rising edge.
RESET  in  1  synchronous, active-high reset.
REQ0  in  1  requester 0 requests a burst.
LEN0  in  LEN_W  requester 0 burst length minus 1; sampled at grant.
VALID0  in  1  DATA0 holds a valid beat.
DATA0  in  DW  requester 0 data.
READY0  out  1  beat on port 0 accepted this cycle when VALID0=1.
GNT0  out  1  port 0 owns the path.
REQ1, LEN1, VALID1, DATA1, READY1, GNT1: same as port 0, for requester 1.
SEL  out  1  mux select: 0=port0, 1=port1; held between bursts.
O_DATA  out  DW  registered output word.
O_VALID  out  1  O_DATA valid.
O_READY  in  1  downstream accepts O_DATA.
BUSY  out  1  asserted when state!=IDLE or O_VALID=1.

Behaviour:
- One clock (CLK). Reset is synchronous and active-high (RESET). All state updates on the rising edge of CLK.
- Reset values: state=IDLE, GNT0=GNT1=0, READY0=READY1=0, SEL=0, O_VALID=0, O_DATA=0, beat count=0, last_owner=1 (so port 0 wins the first tie).
- States: IDLE, XFER, REL.
- IDLE:
  - With no REQ, remain in IDLE.
  - With a single REQx, grant x.
  - With REQ0 and REQ1 together, grant the port that is not last_owner.
  - On a grant: next cycle GNTx=1, SEL=x, cnt=LENx, state=XFER. Grant latency is 1 cycle from REQ to GNT.
- XFER:
  - can_load = !O_VALID | O_READY.
  - READY of the owner = can_load. The non-owner's READY is 0.
  - A beat transfers when VALIDowner & READYowner. On a transfer, O_DATA is loaded with the selected data and O_VALID is set to 1.
  - If cnt!=0 on a transfer, cnt decrements. If cnt==0 on a transfer, the beat is last: next state=REL, GNT drops, last_owner=owner.
  - REQ deassertion during XFER is ignored; a granted burst always completes.
  - An owner stalling (VALID=0) holds the grant indefinitely. There is no timeout.
- REL: one bubble cycle with no grant. Unconditional return to IDLE, so arbitration resumes on the following cycle. The minimum gap between the last beat of one burst and the first GNT of the next is 2 cycles.
- Output stage:
  - O_VALID clears when O_READY=1 and no load occurs in the same cycle.
  - O_DATA is stable while O_VALID & !O_READY.
  - A simultaneous pop and load gives O_VALID=1 with the new data.
  - Input-to-output latency is 1 cycle. Full throughput is 1 beat/cycle while O_READY=1.
- SEL changes only on a grant. It is never changed during XFER or while O_VALID holds a beat from the other port.
- Width rules: data passes through unmodified at DW bits, with no arithmetic. cnt is LEN_W bits, and LEN=2^LEN_W-1 gives 16 beats with no wrap.
- RESET during XFER: the burst is aborted, the pending O_DATA is discarded (O_VALID=0), and all reset values apply on the next cycle.

Decomposition:
- Shared package:
  - DW constant.
  - State encoding: IDLE=2'd0, XFER=2'd1, REL=2'd2.
  - Port index constants P0=0, P1=1.
- Sub-module: instantiate the existing 17-bit 2:1 mux (MUX17bit), with IN0=DATA0, IN1=DATA1 and sel=SEL. Its output feeds the O_DATA register.
- Arbitration and counting stay in this module.

Test Plan:
- Reset then idle: hold RESET for 2 cycles -> all outputs 0, BUSY=0. REQ0=1, LEN0=0, VALID0=1, DATA0=17'h1ABCD -> GNT0 one cycle after REQ0; O_DATA=17'h1ABCD with O_VALID=1 one cycle after the beat; REL; IDLE.
- Tie and round-robin: REQ0=REQ1=1 continuously, LEN0=LEN1=1 -> grant order P0, P1, P0, P1. Each burst is 2 beats, with 2 idle cycles between bursts. SEL toggles only at grants.
- Backpressure: port 1 sends LEN1=3 with data 1,2,3,4 while O_READY=0 for 3 cycles starting at beat 2 -> READY1=0 during the stall, O_DATA holds 2, and all 4 words arrive in order with no loss or duplication.
- Max burst: LEN0=15 with O_READY=1 -> exactly 16 accepted beats, and GNT0 drops right after the 16th. A REQ1 raised mid-burst is granted only after REL.
- Stalled owner: port 0 granted with VALID0=0 for 10 cycles while REQ1=1 -> GNT0 stays 1 and port 1 waits. Both ports then complete normally.
- Reset mid-burst: RESET asserted at beat 2 of a 4-beat burst -> next cycle state=IDLE, O_VALID=0, SEL=0. A subsequent tie is granted to P0.
